// File: rtl/fc_dbuf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_dbuf_sequencer
// Function : Control sequencer for a single-MAC fully-connected datapath.
//            Loads N-element x vectors into a bank flagged buffer and
//            sequences M dot products per vector. It drives the x-buffer and
//            W ROM addresses, the accumulator clear and enable, and the
//            result handshake.
// Options  : FC_DBUF_EN - two x banks, so vector k+1 loads while vector k
//            computes. When undefined, one bank and serialized load/compute.
// Revision : 1.0 - initial release
// ============================================================================
module fc_dbuf_sequencer #(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      input_valid,
    output logic                      input_ready,
    output logic                      output_valid,
    input  logic                      output_ready,
    output logic                      wr_en_x,
    output logic [$clog2(N)-1:0]      addr_x_wr,
    output logic                      bank_wr,
    output logic [$clog2(N)-1:0]      addr_x_rd,
    output logic                      bank_rd,
    output logic [$clog2(M*N)-1:0]    addr_w,
    output logic                      clear_acc,
    output logic                      en_acc,
    output logic [$clog2(M)-1:0]      out_row,
    output logic                      out_last
);

    localparam int c_XW = $clog2(N);
    localparam int c_WW = $clog2(M*N);
    localparam int c_RW = $clog2(M);
    localparam int c_DW = $clog2(LAT+1);

    localparam logic [c_XW-1:0] c_COL_LAST   = c_XW'(N-1);
    localparam logic [c_RW-1:0] c_ROW_LAST   = c_RW'(M-1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(LAT-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_XW-1:0]   r_wcnt;
    logic [c_XW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic [c_DW-1:0]   r_dcnt;
    logic [LAT-1:0]    r_issue_sr;

    logic w_full_wr;
    logic w_full_rd;
    logic w_bank_wr;
    logic w_bank_rd;
    logic w_accept;
    logic w_load_done;
    logic w_release;
    logic w_issue;

    // Held low during reset so nothing is accepted until reset is released
    assign input_ready = ~reset & ~w_full_wr;
    assign w_accept    = input_valid & input_ready;
    assign w_load_done = w_accept & (r_wcnt == c_COL_LAST);
    assign w_release   = (r_state == S_OUT) & output_ready & (r_row == c_ROW_LAST);
    assign w_issue     = (r_state == S_ISSUE);

`ifdef FC_DBUF_EN
    logic [1:0] r_full;
    logic       r_bank_wr;
    logic       r_bank_rd;

    // Bank flags: loader sets its bank, compute releases its bank; never the same bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full    <= 2'b00;
            r_bank_wr <= 1'b0;
            r_bank_rd <= 1'b0;
        end else begin
            if (w_load_done) begin
                r_full[r_bank_wr] <= 1'b1;
                r_bank_wr         <= ~r_bank_wr;
            end
            if (w_release) begin
                r_full[r_bank_rd] <= 1'b0;
                r_bank_rd         <= ~r_bank_rd;
            end
        end
    end

    assign w_bank_wr = r_bank_wr;
    assign w_bank_rd = r_bank_rd;
    assign w_full_wr = r_full[r_bank_wr];
    assign w_full_rd = r_full[r_bank_rd];
`else
    logic r_full;

    // Single bank flag: set when a vector finishes loading, cleared after its last row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (w_load_done) begin
            r_full <= 1'b1;
        end else if (w_release) begin
            r_full <= 1'b0;
        end
    end

    assign w_bank_wr = 1'b0;
    assign w_bank_rd = 1'b0;
    assign w_full_wr = r_full;
    assign w_full_rd = r_full;
`endif

    // Loader element counter; a partial vector is lost on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if (w_load_done) begin
            r_wcnt <= '0;
        end else if (w_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Compute FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Compute FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_full_rd)              w_state_nxt = S_CLEAR;
            S_CLEAR:                             w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_col == c_COL_LAST)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_dcnt == c_DRAIN_LAST) w_state_nxt = S_OUT;
            S_OUT: begin
                if (output_ready) begin
                    w_state_nxt = (r_row == c_ROW_LAST) ? S_IDLE : S_CLEAR;
                end
            end
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    // Row, column and drain counters advanced by the compute state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_row  <= '0;
                S_CLEAR: r_col  <= '0;
                S_ISSUE: begin
                    r_col  <= r_col + 1'b1;
                    r_dcnt <= '0;
                end
                S_DRAIN: r_dcnt <= r_dcnt + 1'b1;
                S_OUT: begin
                    if (output_ready && (r_row != c_ROW_LAST)) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Issue-valid delay line: en_acc lines up with product arrival LAT cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_sr <= '0;
        end else begin
            r_issue_sr[0] <= w_issue;
            for (int i = 1; i < LAT; i++) begin
                r_issue_sr[i] <= r_issue_sr[i-1];
            end
        end
    end

    assign wr_en_x      = w_accept;
    assign addr_x_wr    = r_wcnt;
    assign bank_wr      = w_bank_wr;
    assign bank_rd      = w_bank_rd;
    assign addr_x_rd    = w_issue ? r_col : '0;
    assign addr_w       = w_issue ? (c_WW'(r_row) * c_WW'(N) + c_WW'(r_col)) : '0;
    assign clear_acc    = (r_state == S_CLEAR);
    assign en_acc       = r_issue_sr[LAT-1];
    assign output_valid = (r_state == S_OUT);
    assign out_row      = output_valid ? r_row : '0;
    assign out_last     = output_valid & (r_row == c_ROW_LAST);

endmodule
`default_nettype wire

// File: tb/tb_fc_dbuf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_dbuf_sequencer
// Function : Scoreboard bench for fc_dbuf_sequencer. The driver pushes one
//            expected result per row when a vector completes loading; the
//            monitor pops on each result handshake and also tracks the
//            expected cycle schedule of every sequencer output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_dbuf_sequencer;

    localparam int M   = 4;
    localparam int N   = 4;
    localparam int LAT = 2;
`ifdef FC_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       input_valid  = 1'b0;
    logic       output_ready = 1'b1;
    logic       input_ready;
    logic       output_valid;
    logic       wr_en_x;
    logic [1:0] addr_x_wr;
    logic       bank_wr;
    logic [1:0] addr_x_rd;
    logic       bank_rd;
    logic [3:0] addr_w;
    logic       clear_acc;
    logic       en_acc;
    logic [1:0] out_row;
    logic       out_last;

    typedef struct {
        int row;
        int last;
    } item_t;

    item_t sb[$];
    int    mq_done[$];

    int n_pass     = 0;
    int n_total    = 0;
    int cyc        = 0;
    int g_acc      = 0;
    int hs_count   = 0;
    int stall_at   = -1;
    int stall_left = 0;

    // monitor model state
    int m_wcnt = 0, m_L = 0, m_R = 0, m_active = 0, m_tclr = 0, m_row = 0;
    int m_lastrel = -100;
    int e_rdy, e_k, e_iss, e_ov;
    item_t it;

    fc_dbuf_sequencer #(.M(M), .N(N), .LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .wr_en_x      (wr_en_x),
        .addr_x_wr    (addr_x_wr),
        .bank_wr      (bank_wr),
        .addr_x_rd    (addr_x_rd),
        .bank_rd      (bank_rd),
        .addr_w       (addr_w),
        .clear_acc    (clear_acc),
        .en_acc       (en_acc),
        .out_row      (out_row),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Monitor: expected schedule of every output plus scoreboard pop on handshake
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            m_wcnt = 0; m_L = 0; m_R = 0; m_active = 0; m_row = 0; m_tclr = 0;
            m_lastrel = -100;
            mq_done.delete();
        end else begin
            e_rdy = ((m_L - m_R) < NB) ? 1 : 0;
            chk("input_ready", input_ready, e_rdy);
            chk("wr_en_x", wr_en_x, (input_valid && e_rdy) ? 1 : 0);
            chk("addr_x_wr", addr_x_wr, m_wcnt);
            chk("bank_wr", bank_wr, (NB == 2) ? (m_L % 2) : 0);
            chk("bank_rd", bank_rd, (NB == 2) ? (m_R % 2) : 0);
            if (!m_active && (m_L > m_R) && (mq_done.size() > 0)) begin
                m_tclr   = ((mq_done[0] > m_lastrel) ? mq_done[0] : m_lastrel) + 2;
                m_active = 1;
                m_row    = 0;
            end
            e_k   = m_active ? (cyc - m_tclr) : -1000;
            e_iss = (e_k >= 1 && e_k <= N) ? 1 : 0;
            e_ov  = (e_k >= N + LAT + 1) ? 1 : 0;
            chk("clear_acc", clear_acc, (e_k == 0) ? 1 : 0);
            chk("addr_w", addr_w, e_iss ? (m_row * N + e_k - 1) : 0);
            chk("addr_x_rd", addr_x_rd, e_iss ? (e_k - 1) : 0);
            chk("en_acc", en_acc, (e_k >= LAT + 1 && e_k <= LAT + N) ? 1 : 0);
            chk("output_valid", output_valid, e_ov);
            if (e_ov) begin
                chk("out_row", out_row, m_row);
                chk("out_last", out_last, (m_row == M - 1) ? 1 : 0);
                if (output_ready) begin
                    chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        it = sb.pop_front();
                        chk("sb_row", out_row, it.row);
                        chk("sb_last", out_last, it.last);
                    end
                    if (m_row < M - 1) begin
                        m_row++;
                        m_tclr = cyc + 1;
                    end else begin
                        m_R++;
                        m_lastrel = cyc;
                        m_active  = 0;
                        if (mq_done.size() > 0) void'(mq_done.pop_front());
                    end
                end
            end
            if (input_valid && e_rdy) begin
                m_wcnt++;
                if (m_wcnt == N) begin
                    m_wcnt = 0;
                    m_L++;
                    mq_done.push_back(cyc);
                end
            end
        end
    end

    // Handshake counter used by the back-pressure driver
    initial forever begin
        @(negedge clk);
        if (!reset && output_valid && output_ready) hs_count++;
    end

    // Downstream ready: drops for stall_left cycles while the armed result is presented
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset && hs_count == stall_at && output_valid && stall_left > 0) begin
            output_ready = 1'b0;
            stall_left--;
        end else begin
            output_ready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1: assert reset, check cleared outputs, release two cycles later
    task automatic do_reset();
        reset       = 1'b1;
        input_valid = 1'b1;
        #1;
        chk("rst_output_valid", output_valid, 0);
        chk("rst_clear_acc", clear_acc, 0);
        chk("rst_en_acc", en_acc, 0);
        chk("rst_wr_en_x", wr_en_x, 0);
        chk("rst_addr_w", addr_w, 0);
        chk("rst_addr_x_rd", addr_x_rd, 0);
        chk("rst_addr_x_wr", addr_x_wr, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_bank_wr", bank_wr, 0);
        chk("rst_bank_rd", bank_rd, 0);
        sb.delete();
        g_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        input_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_input_ready", input_ready, 1);
    endtask

    // Stream ne elements with input_valid held high; push M results per full vector
    task automatic send(input int ne);
        int cnt;
        int waitc;
        cnt   = 0;
        waitc = 0;
        @(posedge clk);
        #1;
        input_valid = 1'b1;
        while (cnt < ne && waitc < 300) begin
            @(negedge clk);
            if (input_ready) begin
                cnt++;
                g_acc++;
                waitc = 0;
                if (g_acc % N == 0) begin
                    for (int r = 0; r < M; r++) sb.push_back('{row: r, last: (r == M - 1) ? 1 : 0});
                end
            end else begin
                waitc++;
            end
        end
        chk("send_accepted", cnt, ne);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // power-on reset
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // partial vector discarded by reset
        send(2);
        do_reset();

        // reset in the second ISSUE cycle
        send(N);
        begin
            int w;
            w = 0;
            while (!clear_acc && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        chk("clear_seen", clear_acc, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();

        // single vector, downstream always ready
        send(N);
        wait_drain();

        // back-pressure on row 1
        stall_at   = hs_count + 1;
        stall_left = 5;
        send(N);
        wait_drain();

        // three vectors with continuous input_valid
        send(3 * N);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_dbuf_sequencer.md
# fc_dbuf_sequencer

Control sequencer for a single-MAC fully-connected datapath: x-vector buffer, W ROM, multiply register and saturating accumulator. It accepts N-element input vectors over a valid/ready stream and sequences M dot products per vector. For each product it drives buffer and ROM addresses, accumulator clear and enable, and the output handshake. With double buffering compiled in, the next vector loads while the current one computes.

## Interface
- `M`, 4: output rows (neurons) per vector.
- `N`, 4: elements per input vector; W ROM holds M*N words, row-major.
- `LAT`, 2: cycles from address issue to product valid at the accumulator input (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `input_valid`  in  1  upstream element valid.
- `input_ready`  out  1  element accepted when `input_valid & input_ready`.
- `output_valid`  out  1  accumulator result valid for downstream.
- `output_ready`  in  1  downstream accepts when `output_valid & output_ready`.
- `wr_en_x`  out  1  x-buffer write strobe (= accept).
- `addr_x_wr`  out  $clog2(N)  x-buffer write index.
- `bank_wr`  out  1  x-buffer write bank.
- `addr_x_rd`  out  $clog2(N)  x-buffer read index.
- `bank_rd`  out  1  x-buffer read bank.
- `addr_w`  out  $clog2(M*N)  W ROM address, row*N+col.
- `clear_acc`  out  1  synchronous accumulator clear.
- `en_acc`  out  1  accumulator load enable, aligned to product arrival.
- `out_row`  out  $clog2(M)  row index of the presented result.
- `out_last`  out  1  presented result is row M-1.

## Operation
- Loader: counter `wcnt` 0..N-1 plus `full[1:0]` bank flags.
  - `input_ready = !full[bank_wr]`.
  - On each accept, `wcnt` increments.
  - On the accept with `wcnt==N-1`: `wcnt←0`, `full[bank_wr]←1`, `bank_wr` toggles.
- Compute FSM states: IDLE, CLEAR, ISSUE, DRAIN, OUT.
  - IDLE: if `full[bank_rd]`, go to CLEAR with `row←0`.
  - CLEAR: `clear_acc=1` for one cycle; `col←0`; go to ISSUE.
  - ISSUE: runs N cycles; `addr_x_rd=col`, `addr_w=row*N+col`, issue-valid=1; after `col==N-1`, go to DRAIN.
  - DRAIN: runs LAT cycles, then OUT.
  - OUT: `output_valid=1`; `out_row=row`; `out_last=(row==M-1)`. Holds until `output_ready`.
    - If `row<M-1`: `row++`, go to CLEAR.
    - Else: `full[bank_rd]←0`, `bank_rd` toggles, go to IDLE.
- `en_acc` = issue-valid delayed by an LAT-stage shift register. It is never asserted in CLEAR or OUT.
- Simultaneous loader-set and compute-release of different banks in one cycle: both take effect. The same bank cannot be set and released in one cycle, because the loader never writes a full bank.
- Addresses outside ISSUE are 0. The loader drives `addr_x_wr` and `bank_wr` continuously.
- Reset, asynchronous, at any time:
  - FSM→IDLE; `wcnt`, `row`, `col`, shift register, `full`, both banks → 0.
  - Outputs: `output_valid=0`, `clear_acc=0`, `en_acc=0`, `wr_en_x=0`, all addresses 0, `out_row=0`, `out_last=0`.
  - `input_ready` goes to 1 after reset deasserts.
  - A partially loaded vector is discarded.

## Timing
- Address outputs and `clear_acc` are registered-state decodes, valid in the cycle of the state.
- `input_ready` and `wr_en_x` are combinational from `full` and `input_valid`.
- Last-element accept in cycle c → `output_valid` first high in cycle c+N+LAT+3.
- Output accepted in cycle o → next row's `output_valid` in cycle o+N+LAT+2.
- `output_valid`, `out_row` and `out_last` are stable while stalled.

## Configuration
- `FC_DBUF_EN` defined:
  - Two x banks; `bank_wr` and `bank_rd` toggle as above.
  - Loading vector k+1 overlaps computation of vector k.
- `FC_DBUF_EN` undefined:
  - One bank; `bank_wr` and `bank_rd` are tied to 0; only `full[0]` exists.
  - `input_ready=0` from the last accept until the row M-1 output is accepted; load and compute are fully serialized.

## Test plan
- Reset mid-ISSUE (M=4, N=4, LAT=2): assert `reset` in cycle 2 of ISSUE → all outputs 0 immediately; `input_ready=1` after release; the next vector computes from row 0.
- Single vector, `output_ready` held 1:
  - Last accept at cycle 10 → `output_valid` at cycle 19.
  - Rows 0..3 at cycles 19, 27, 35, 43.
  - `addr_w` sequence 0..15.
  - `out_last=1` only at cycle 43.
- Back-pressure: `output_ready=0` for 5 cycles at row 1 → `output_valid`, `out_row=1` held; no `en_acc` or `clear_acc` during the stall; row 2 appears 8 cycles after acceptance.
- `FC_DBUF_EN` defined, continuous `input_valid`:
  - Vector 2 fully accepted during vector 1's compute, writing bank 1.
  - Vector 3 stalls (`input_ready=0`) until vector 1's row 3 is accepted.
  - `bank_rd` then reads 1.
- `FC_DBUF_EN` undefined, continuous `input_valid`: `input_ready=0` from the 4th accept until the cycle after the row-3 handshake.
- `en_acc` alignment, LAT=3: exactly N `en_acc` pulses per row, each 3 cycles after its issue cycle, contiguous.
